stdp_update_scheduler: RTL and testbench
========================================

// Module: stdp_update_scheduler
// PURPOSE
//  Sequences STDP weight updates for an N_PRE x N_POST synapse array through one shared STDP update unit.
//  Keeps a timestep counter and last-spike timestamp tables for pre and post neurons.
//  On each post spike it walks every pre partner (LTP). On each pre spike it walks every post partner (LTD).
//  For each eligible pair: read weight, issue the delta to the STDP unit, write the result back.
//  Sits between the spike fabric, the synaptic weight memory and the STDP unit.
// PARAMETERS
//  N_PRE   8   number of pre-synaptic neurons
//  N_POST  8   number of post-synaptic neurons
//  TS_W    8   timestep counter / timestamp width
//  DT_W    9   signed delta width sent to STDP unit (must be TS_W+1)
//  W_W     8   weight width
//  WINDOW  31  max |delta| in timesteps that triggers an update
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  async active-low reset
//  kill           in   1                  sync; 1 = stop scheduling (see below)
//  ts_tick        in   1                  timestep advance strobe (1 cycle)
//  pre_spike      in   N_PRE              pre spikes of new timestep, sampled on ts_tick
//  post_spike     in   N_POST             post spikes of new timestep, sampled on ts_tick
//  wmem_rd_en     out  1                  weight read strobe
//  wmem_wr_en     out  1                  weight write strobe
//  wmem_addr      out  clog2(N_PRE*N_POST) pre_idx*N_POST+post_idx
//  wmem_rd_data   in   W_W                read data, valid exactly 1 cycle after wmem_rd_en
//  wmem_wr_data   out  W_W                write data
//  stdp_req_valid out  1                  request to STDP unit
//  stdp_req_ready in   1                  STDP unit accepts
//  stdp_delta     out  DT_W               signed t_post - t_pre
//  stdp_weight    out  W_W                current weight
//  stdp_rsp_valid in   1                  STDP result valid (any latency >=1)
//  stdp_new_weight in  W_W                updated weight
//  busy           out  1                  FSM not IDLE or any pending bit set
//  overrun        out  1                  sticky: ts_tick arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; ts counter=0; pending bitmaps, timestamp-valid bits and FSM cleared (IDLE).
//  ts_tick with kill=0:
//   - t_now increments mod 2^TS_W.
//   - For each spiking neuron: ts table <- new t_now, valid <- 1, pending bit <- 1.
//  Age(x) = (t_now - ts[x]) mod 2^TS_W.
//  Eligible pair: partner valid and Age <= WINDOW. Pre jobs also require Age != 0, so simultaneous spikes count once, as LTP.
//  Deltas: post job gives stdp_delta = +Age(pre). Pre job gives stdp_delta = -Age(post). Both are DT_W two's complement.
//  Job select: round-robin over post pending bits first. Pre pending bits are served only when no post bit is set.
//  Arbiter pointer advances past each granted index.
//  FSM:
//   IDLE -> SEL when any pending bit is set.
//   SEL -> SCAN with partner k=0.
//   SCAN: ineligible k skips in 1 cycle. Eligible k -> RD.
//   RD: wmem_rd_en=1 for 1 cycle -> WAIT.
//   WAIT: capture rd_data -> REQ.
//   REQ: hold valid/delta/weight stable until ready -> RSP.
//   RSP: wait for rsp_valid, capture new weight -> WR.
//   WR: wmem_wr_en=1 for 1 cycle, same addr -> SCAN with k+1.
//   After the last k: clear that pending bit -> SEL if more bits are set, else IDLE.
//  ts_tick while busy: overrun <- 1 (sticky until rst). Tables and pending bits still update.
//   Remaining pairs use the current table values.
//  kill=1: ts_tick is ignored and all pending bits are cleared at once. The in-flight pair completes through WR, then IDLE.
//   A REQ already raised is never dropped.
//  Timestamp wrap: Age is computed modulo, so it is correct across the 255->0 wrap.
//   Stale entries older than 2^TS_W aliasing are accepted behaviour.
//  Minimum cost per eligible pair: 5 cycles + STDP unit latency.
// STRUCTURE
//  stdp_pkg: FSM state enum, DT_W/TS_W constants, age/eligibility function.
//  Sub-module stdp_rr_arbiter (N requests, one-hot grant, pointer update on accept).
//  It is instantiated twice, for post and pre pending bits.
// TESTING
//  1 Pre spike neuron 2 at t=3, post spike neuron 5 at t=7 -> one request delta=+4, addr=21, written weight = STDP response.
//  2 Post 1 at t=10, pre 0 at t=12 -> one LTD request delta=-2, addr=1. No LTP request for post 1 (pre 0 not valid at t=10).
//  3 Pre 4 and post 4 in same tick -> exactly one request, delta=0; pre job skips the pair.
//  4 Pre 0 at t=250, post 0 at t=4 after wrap -> delta=+10; with ages 40 (>WINDOW) -> no request.
//  5 Posts 1,3,6 in one tick, STDP ready held low 20 cycles -> request fields stable.
//    Jobs are served in order 1,3,6; a ts_tick during this sets overrun.
//  6 kill asserted in RSP -> write completes, pending cleared, busy=0. rst mid-job -> all outputs 0 at once.

Source files
------------

// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP update scheduler.
// FSM encoding, default widths and pair eligibility test.
package stdp_pkg;

  localparam int STDP_TS_W = 8;
  localparam int STDP_DT_W = STDP_TS_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SCAN,
    S_RD,
    S_WAIT,
    S_REQ,
    S_RSP,
    S_WR
  } state_e;

  // Pre jobs drop age 0 so a same-tick pair is handled once, as LTP.
  function automatic logic pair_eligible(
    input logic        vld,
    input int unsigned age,
    input int unsigned window,
    input logic        pre_job
  );
    return vld && (age <= window) && !(pre_job && (age == 0));
  endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index.
// Pointer moves past the granted index on accept.
module stdp_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    // Descending walk: the request closest to the pointer wins last.
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (IW + 1)'(i);
      if (idx >= (IW + 1)'(N)) idx = idx - (IW + 1)'(N);
      if (req[idx[IW-1:0]]) begin
        gnt              = '0;
        gnt[idx[IW-1:0]] = 1'b1;
        gnt_idx          = idx[IW-1:0];
      end
    end
    ptr_d = ptr_q;
    if (accept && |req) begin
      if (gnt_idx == IW'(N - 1)) ptr_d = '0;
      else ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Walks STDP pairs for pre/post spikes through one shared STDP unit.
// Read weight, issue delta, write result back; post jobs first.
module stdp_update_scheduler
  import stdp_pkg::*;
#(
  parameter int N_PRE  = 8,
  parameter int N_POST = 8,
  parameter int TS_W   = STDP_TS_W,
  parameter int DT_W   = STDP_DT_W,
  parameter int W_W    = 8,
  parameter int WINDOW = 31
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            kill,
  input  logic                            ts_tick,
  input  logic [N_PRE-1:0]                pre_spike,
  input  logic [N_POST-1:0]               post_spike,
  output logic                            wmem_rd_en,
  output logic                            wmem_wr_en,
  output logic [$clog2(N_PRE*N_POST)-1:0] wmem_addr,
  input  logic [W_W-1:0]                  wmem_rd_data,
  output logic [W_W-1:0]                  wmem_wr_data,
  output logic                            stdp_req_valid,
  input  logic                            stdp_req_ready,
  output logic [DT_W-1:0]                 stdp_delta,
  output logic [W_W-1:0]                  stdp_weight,
  input  logic                            stdp_rsp_valid,
  input  logic [W_W-1:0]                  stdp_new_weight,
  output logic                            busy,
  output logic                            overrun
);

  localparam int NMAX = (N_PRE > N_POST) ? N_PRE : N_POST;
  localparam int IW   = $clog2(NMAX);
  localparam int KW   = IW + 1;
  localparam int AW   = $clog2(N_PRE * N_POST);

  state_e            state_q, state_d;
  logic [TS_W-1:0]   t_now_q, t_now_d;
  logic [TS_W-1:0]   pre_ts_q  [N_PRE];
  logic [TS_W-1:0]   pre_ts_d  [N_PRE];
  logic [TS_W-1:0]   post_ts_q [N_POST];
  logic [TS_W-1:0]   post_ts_d [N_POST];
  logic [N_PRE-1:0]  pre_vld_q, pre_vld_d, pre_pend_q, pre_pend_d;
  logic [N_POST-1:0] post_vld_q, post_vld_d, post_pend_q, post_pend_d;
  logic              job_post_q, job_post_d;
  logic [IW-1:0]     job_idx_q, job_idx_d;
  logic [NMAX-1:0]   job_oh_q, job_oh_d;
  logic [KW-1:0]     k_q, k_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DT_W-1:0]   delta_q, delta_d;
  logic [W_W-1:0]    w_q, w_d;
  logic              abort_q, abort_d;
  logic              overrun_q, overrun_d;

  logic              tick_ok, abort, job_done, more;
  logic              post_acc, pre_acc;
  logic [N_POST-1:0] post_gnt, post_mask;
  logic [N_PRE-1:0]  pre_gnt, pre_mask;
  logic [IW-1:0]     post_idx, pre_idx, pk, pre_i, post_i;
  logic              part_vld, elig;
  logic [TS_W-1:0]   part_ts, age;
  logic [KW-1:0]     n_part;
  logic [AW-1:0]     pair_addr;

  stdp_rr_arbiter #(.N(N_POST), .IW(IW)) u_post_arb (
    .clk(clk), .rst(rst), .req(post_pend_q), .accept(post_acc),
    .gnt(post_gnt), .gnt_idx(post_idx)
  );

  stdp_rr_arbiter #(.N(N_PRE), .IW(IW)) u_pre_arb (
    .clk(clk), .rst(rst), .req(pre_pend_q), .accept(pre_acc),
    .gnt(pre_gnt), .gnt_idx(pre_idx)
  );

  assign tick_ok   = ts_tick & ~kill;
  assign abort     = abort_q | kill;
  assign busy      = (state_q != S_IDLE) | (|pre_pend_q) | (|post_pend_q);
  assign post_mask = job_post_q ? N_POST'(job_oh_q) : '0;
  assign pre_mask  = job_post_q ? '0 : N_PRE'(job_oh_q);
  assign more      = |(post_pend_q & ~post_mask) | |(pre_pend_q & ~pre_mask);

  // Partner k of the current job and its timestamp age.
  assign pk        = k_q[IW-1:0];
  assign part_vld  = job_post_q ? pre_vld_q[pk] : post_vld_q[pk];
  assign part_ts   = job_post_q ? pre_ts_q[pk] : post_ts_q[pk];
  assign age       = t_now_q - part_ts;
  assign n_part    = job_post_q ? KW'(N_PRE) : KW'(N_POST);
  assign elig      = pair_eligible(part_vld, 32'(age), WINDOW, !job_post_q);
  assign pre_i     = job_post_q ? pk : job_idx_q;
  assign post_i    = job_post_q ? job_idx_q : pk;
  assign pair_addr = AW'(int'(pre_i) * N_POST + int'(post_i));

  always_comb begin
    state_d    = state_q;
    job_post_d = job_post_q;
    job_idx_d  = job_idx_q;
    job_oh_d   = job_oh_q;
    k_d        = k_q;
    addr_d     = addr_q;
    delta_d    = delta_q;
    w_d        = w_q;
    job_done   = 1'b0;
    post_acc   = 1'b0;
    pre_acc    = 1'b0;
    unique case (state_q)
      S_IDLE: if (busy && !kill) state_d = S_SEL;
      S_SEL: begin
        if (abort) state_d = S_IDLE;
        else if (|post_pend_q) begin
          post_acc   = 1'b1;
          job_post_d = 1'b1;
          job_idx_d  = post_idx;
          job_oh_d   = NMAX'(post_gnt);
          k_d        = '0;
          state_d    = S_SCAN;
        end else if (|pre_pend_q) begin
          pre_acc    = 1'b1;
          job_post_d = 1'b0;
          job_idx_d  = pre_idx;
          job_oh_d   = NMAX'(pre_gnt);
          k_d        = '0;
          state_d    = S_SCAN;
        end else state_d = S_IDLE;
      end
      S_SCAN: begin
        if (abort) state_d = S_IDLE;
        else if (k_q == n_part) begin
          job_done = 1'b1;
          state_d  = more ? S_SEL : S_IDLE;
        end else if (elig) begin
          addr_d  = pair_addr;
          delta_d = job_post_q ? DT_W'({1'b0, age}) : DT_W'(-{1'b0, age});
          state_d = S_RD;
        end else k_d = k_q + 1'b1;
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        w_d     = wmem_rd_data;
        state_d = S_REQ;
      end
      S_REQ: if (stdp_req_ready) state_d = S_RSP;
      S_RSP: begin
        if (stdp_rsp_valid) begin
          w_d     = stdp_new_weight;
          state_d = S_WR;
        end
      end
      S_WR: begin
        k_d     = k_q + 1'b1;
        state_d = abort ? S_IDLE : S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
    abort_d = abort && (state_d != S_IDLE);
  end

  always_comb begin
    t_now_d     = t_now_q;
    pre_ts_d    = pre_ts_q;
    post_ts_d   = post_ts_q;
    pre_vld_d   = pre_vld_q;
    post_vld_d  = post_vld_q;
    pre_pend_d  = pre_pend_q;
    post_pend_d = post_pend_q;
    overrun_d   = overrun_q;
    if (job_done) begin
      pre_pend_d  = pre_pend_q & ~pre_mask;
      post_pend_d = post_pend_q & ~post_mask;
    end
    // A new spike on the finishing job re-arms it: set wins over clear.
    if (tick_ok) begin
      t_now_d   = t_now_q + 1'b1;
      overrun_d = overrun_q | busy;
      for (int i = 0; i < N_PRE; i++) begin
        if (pre_spike[i]) begin
          pre_ts_d[i]   = t_now_d;
          pre_vld_d[i]  = 1'b1;
          pre_pend_d[i] = 1'b1;
        end
      end
      for (int i = 0; i < N_POST; i++) begin
        if (post_spike[i]) begin
          post_ts_d[i]   = t_now_d;
          post_vld_d[i]  = 1'b1;
          post_pend_d[i] = 1'b1;
        end
      end
    end
    if (kill) begin
      pre_pend_d  = '0;
      post_pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      t_now_q     <= '0;
      pre_vld_q   <= '0;
      post_vld_q  <= '0;
      pre_pend_q  <= '0;
      post_pend_q <= '0;
      job_post_q  <= 1'b0;
      job_idx_q   <= '0;
      job_oh_q    <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      delta_q     <= '0;
      w_q         <= '0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_PRE; i++) pre_ts_q[i] <= '0;
      for (int i = 0; i < N_POST; i++) post_ts_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      t_now_q     <= t_now_d;
      pre_vld_q   <= pre_vld_d;
      post_vld_q  <= post_vld_d;
      pre_pend_q  <= pre_pend_d;
      post_pend_q <= post_pend_d;
      job_post_q  <= job_post_d;
      job_idx_q   <= job_idx_d;
      job_oh_q    <= job_oh_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      delta_q     <= delta_d;
      w_q         <= w_d;
      abort_q     <= abort_d;
      overrun_q   <= overrun_d;
      pre_ts_q    <= pre_ts_d;
      post_ts_q   <= post_ts_d;
    end
  end

  assign wmem_rd_en     = (state_q == S_RD);
  assign wmem_wr_en     = (state_q == S_WR);
  assign wmem_addr      = addr_q;
  assign wmem_wr_data   = w_q;
  assign stdp_req_valid = (state_q == S_REQ);
  assign stdp_delta     = delta_q;
  assign stdp_weight    = w_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Scoreboard bench for stdp_update_scheduler.
// Weight memory and STDP unit are modelled here.
module tb_stdp_update_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kill = 1'b0;
  logic       ts_tick = 1'b0;
  logic [7:0] pre_spike = '0;
  logic [7:0] post_spike = '0;
  logic       wmem_rd_en, wmem_wr_en;
  logic [5:0] wmem_addr;
  logic [7:0] wmem_rd_data;
  logic [7:0] wmem_wr_data;
  logic       stdp_req_valid;
  logic       stdp_req_ready = 1'b1;
  logic [8:0] stdp_delta;
  logic [7:0] stdp_weight;
  logic       stdp_rsp_valid = 1'b0;
  logic [7:0] stdp_new_weight = '0;
  logic       busy, overrun;

  typedef struct {
    logic [5:0] addr;
    logic [8:0] delta;
  } exp_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  exp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [7:0] mem[64];
  int         checks = 0;
  int         errors = 0;
  int         tnow = 0;
  int         rsp_lat = 2;

  stdp_update_scheduler dut (
    .clk(clk), .rst(rst), .kill(kill), .ts_tick(ts_tick),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .wmem_rd_en(wmem_rd_en), .wmem_wr_en(wmem_wr_en),
    .wmem_addr(wmem_addr), .wmem_rd_data(wmem_rd_data),
    .wmem_wr_data(wmem_wr_data),
    .stdp_req_valid(stdp_req_valid), .stdp_req_ready(stdp_req_ready),
    .stdp_delta(stdp_delta), .stdp_weight(stdp_weight),
    .stdp_rsp_valid(stdp_rsp_valid), .stdp_new_weight(stdp_new_weight),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_w(input int a);
    return 8'(a * 5 + 3);
  endfunction

  function automatic logic [7:0] stdp_model(input logic [7:0] w, input logic [8:0] d);
    logic [7:0] lo;
    lo = d[7:0];
    return w + lo + 8'h11;
  endfunction

  // Weight memory: read data one cycle after rd_en.
  always @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < 64; a++) mem[a] <= init_w(a);
      wmem_rd_data <= '0;
    end else begin
      if (wmem_rd_en) wmem_rd_data <= mem[wmem_addr];
      if (wmem_wr_en) mem[wmem_addr] <= wmem_wr_data;
    end
  end

  // STDP unit: answers rsp_lat cycles after the accepting edge.
  always @(negedge clk) begin : stdp_unit
    logic [7:0] nw;
    if (rst && stdp_req_valid && stdp_req_ready) begin
      nw = stdp_model(stdp_weight, stdp_delta);
      @(posedge clk);
      repeat (rsp_lat - 1) @(posedge clk);
      #1;
      stdp_rsp_valid  = 1'b1;
      stdp_new_weight = nw;
      @(posedge clk);
      #1;
      stdp_rsp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    wr_t  w;
    if (rst && stdp_req_valid && stdp_req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req addr=%0d delta=%0d", wmem_addr, $signed(stdp_delta));
      end else begin
        e = exp_q.pop_front();
        if (stdp_delta !== e.delta || wmem_addr !== e.addr || stdp_weight !== mem[e.addr]) begin
          errors++;
          $display("FAIL req got addr=%0d delta=%0d w=%0d want addr=%0d delta=%0d w=%0d",
                   wmem_addr, $signed(stdp_delta), stdp_weight,
                   e.addr, $signed(e.delta), mem[e.addr]);
        end
        w.addr = e.addr;
        w.data = stdp_model(mem[e.addr], e.delta);
        wr_q.push_back(w);
      end
    end
    if (rst && wmem_wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr addr=%0d data=%0d", wmem_addr, wmem_wr_data);
      end else begin
        w = wr_q.pop_front();
        if (wmem_addr !== w.addr || wmem_wr_data !== w.data) begin
          errors++;
          $display("FAIL wr got addr=%0d data=%0d want addr=%0d data=%0d",
                   wmem_addr, wmem_wr_data, w.addr, w.data);
        end
      end
    end
  end

  task automatic push_exp(input int a, input int d);
    exp_t e;
    e.addr  = 6'(a);
    e.delta = 9'(d);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    kill = 1'b0;
    ts_tick = 1'b0;
    pre_spike = '0;
    post_spike = '0;
    stdp_req_ready = 1'b1;
    rsp_lat = 2;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tnow = 0;
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic tick(input logic [7:0] pre, input logic [7:0] post);
    @(posedge clk);
    #1;
    ts_tick = 1'b1;
    pre_spike = pre;
    post_spike = post;
    @(posedge clk);
    #1;
    ts_tick = 1'b0;
    pre_spike = '0;
    post_spike = '0;
    tnow++;
  endtask

  task automatic tick_to(input int t, input logic [7:0] pre, input logic [7:0] post);
    while (tnow < t - 1) tick(8'h00, 8'h00);
    tick(pre, post);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout busy=%b want 0", busy);
    end
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!stdp_req_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!stdp_req_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_req timeout valid=%b want 1", stdp_req_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({stdp_req_valid, wmem_rd_en, wmem_wr_en, wmem_addr, wmem_wr_data,
         stdp_delta, stdp_weight, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs v=%b rd=%b wr=%b addr=%0d busy=%b ovr=%b want all 0",
               stdp_req_valid, wmem_rd_en, wmem_wr_en, wmem_addr, busy, overrun);
    end
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b ovr=%b want 0 0", busy, overrun);
    end
  endtask

  task automatic test_ltp();
    do_reset();
    tick_to(3, 8'h04, 8'h00);
    wait_idle(100);
    push_exp(21, 4);
    tick_to(7, 8'h00, 8'h20);
    wait_idle(200);
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL ltp_drain req_left=%0d wr_left=%0d want 0 0", exp_q.size(), wr_q.size());
    end
  endtask

  task automatic test_ltd();
    do_reset();
    tick_to(10, 8'h00, 8'h02);
    wait_idle(100);
    push_exp(1, -2);
    tick_to(12, 8'h01, 8'h00);
    wait_idle(200);
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL ltd_drain req_left=%0d wr_left=%0d want 0 0", exp_q.size(), wr_q.size());
    end
  endtask

  task automatic test_same_tick();
    do_reset();
    push_exp(36, 0);
    tick_to(1, 8'h10, 8'h10);
    wait_idle(300);
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_tick req_left=%0d wr_left=%0d ovr=%b want 0 0 0",
               exp_q.size(), wr_q.size(), overrun);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick_to(250, 8'h01, 8'h00);
    wait_idle(100);
    push_exp(0, 10);
    tick_to(260, 8'h00, 8'h01);
    wait_idle(200);
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_delta req_left=%0d wr_left=%0d want 0 0", exp_q.size(), wr_q.size());
    end
    do_reset();
    tick_to(220, 8'h01, 8'h00);
    wait_idle(100);
    tick_to(260, 8'h00, 8'h01);
    wait_idle(200);
    checks++;
    if (busy !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_window busy=%b wr_left=%0d want 0 0", busy, wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] d0;
    logic [7:0] w0;
    do_reset();
    tick_to(1, 8'h01, 8'h00);
    wait_idle(100);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_early got %b want 0", overrun);
    end
    stdp_req_ready = 1'b0;
    push_exp(1, 2);
    push_exp(3, 3);
    push_exp(6, 3);
    tick_to(3, 8'h00, 8'h4A);
    wait_req(100);
    d0 = stdp_delta;
    w0 = stdp_weight;
    checks++;
    if (d0 !== 9'd2) begin
      errors++;
      $display("FAIL stall_first_delta got %0d want 2", $signed(d0));
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ts_tick = (i == 5);
      @(negedge clk);
      checks++;
      if ({stdp_req_valid, stdp_delta, stdp_weight} !== {1'b1, d0, w0}) begin
        errors++;
        $display("FAIL req_stable cyc=%0d got v=%b d=%0d w=%0d want v=1 d=%0d w=%0d",
                 i, stdp_req_valid, $signed(stdp_delta), stdp_weight, $signed(d0), w0);
      end
    end
    @(posedge clk);
    #1;
    stdp_req_ready = 1'b1;
    wait_idle(300);
    checks++;
    if (overrun !== 1'b1 || exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end ovr=%b req_left=%0d wr_left=%0d want 1 0 0",
               overrun, exp_q.size(), wr_q.size());
    end
  endtask

  task automatic test_kill();
    do_reset();
    rsp_lat = 6;
    tick_to(1, 8'h01, 8'h00);
    wait_idle(100);
    push_exp(1, 1);
    tick_to(2, 8'h00, 8'h0A);
    wait_req(100);
    @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL kill busy=%b req_left=%0d wr_left=%0d want 0 0 0",
               busy, exp_q.size(), wr_q.size());
    end
  endtask

  task automatic test_rst_mid_job();
    do_reset();
    tick_to(1, 8'h01, 8'h00);
    wait_idle(100);
    stdp_req_ready = 1'b0;
    push_exp(2, 1);
    tick_to(2, 8'h00, 8'h04);
    wait_req(100);
    rst = 1'b0;
    #1;
    checks++;
    if ({stdp_req_valid, wmem_rd_en, wmem_wr_en, wmem_addr, wmem_wr_data,
         stdp_delta, stdp_weight, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL rst_mid_job v=%b addr=%0d d=%0d w=%0d busy=%b want all 0",
               stdp_req_valid, wmem_addr, $signed(stdp_delta), stdp_weight, busy);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_ltp();
    test_ltd();
    test_same_tick();
    test_wrap();
    test_back_to_back();
    test_kill();
    test_rst_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
